// File: rtl/wb_regfile_if.sv
// ---------------------------------------------------------------------------
// wb_regfile_if
// Bundle between the MEM/WB pipeline register, the ID-stage read ports and
// the writeback/register-file block.
//   master : drives the WB-slot fields and read addresses, sees the results
//   slave  : the register-file block itself
// Signals:
//   valid, regWrite, memToReg[2:0], ALUResult, memData, PCPlus4, imm,
//   loadType[2:0], RD[4:0]      -- WB slot contents
//   rs1[4:0], rs2[4:0]          -- ID-stage read addresses
//   readData1, readData2        -- bypassed register values
//   wbData                      -- selected writeback value
//   instretCount[31:0]          -- retired-instruction counter
// ---------------------------------------------------------------------------
interface wb_regfile_if #(
    parameter int XLEN = 32
);
    logic            valid;
    logic            regWrite;
    logic [2:0]      memToReg;
    logic [XLEN-1:0] ALUResult;
    logic [XLEN-1:0] memData;
    logic [XLEN-1:0] PCPlus4;
    logic [XLEN-1:0] imm;
    logic [2:0]      loadType;
    logic [4:0]      RD;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] readData1;
    logic [XLEN-1:0] readData2;
    logic [XLEN-1:0] wbData;
    logic [31:0]     instretCount;

    modport master (
        output valid, regWrite, memToReg, ALUResult, memData, PCPlus4, imm,
               loadType, RD, rs1, rs2,
        input  readData1, readData2, wbData, instretCount
    );

    modport slave (
        input  valid, regWrite, memToReg, ALUResult, memData, PCPlus4, imm,
               loadType, RD, rs1, rs2,
        output readData1, readData2, wbData, instretCount
    );
endinterface

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
// Writeback stage of the RISC-V pipeline: picks the writeback value, extracts
// and extends load data, writes the integer register file, serves the two
// ID-stage read ports with write-first bypass and counts retired instructions.
// Ports:
//   clk  -- rising-edge clock
//   rst  -- synchronous active-high reset (clears registers and counter)
//   bus  -- wb_regfile_if.slave (WB slot inputs, read ports, wbData, counter)
// ---------------------------------------------------------------------------
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic          clk,
    input  logic          rst,
    wb_regfile_if.slave   bus
);

    logic [XLEN-1:0] regs_r [NREGS];
    logic [31:0]     instret_r;

    logic [1:0]      off_s;
    logic [7:0]      byte_s;
    logic [15:0]     half_s;
    logic [XLEN-1:0] load_s;
    logic [XLEN-1:0] wb_s;
    logic            reserved_s;
    logic            we_s;
    logic [XLEN-1:0] rd1_s;
    logic [XLEN-1:0] rd2_s;

    // Load extraction: pick the addressed byte/halfword and extend it.
    always_comb begin
        off_s  = bus.ALUResult[1:0];
        byte_s = 8'h00;
        case (off_s)
            2'd0:    byte_s = bus.memData[7:0];
            2'd1:    byte_s = bus.memData[15:8];
            2'd2:    byte_s = bus.memData[23:16];
            2'd3:    byte_s = bus.memData[31:24];
            default: byte_s = 8'h00;
        endcase
        // off[0] is ignored for halfwords: no misalignment trap in this core.
        if (off_s[1]) begin
            half_s = bus.memData[31:16];
        end else begin
            half_s = bus.memData[15:0];
        end
        case (bus.loadType)
            3'b000:  load_s = {{(XLEN-8){byte_s[7]}}, byte_s};
            3'b001:  load_s = {{(XLEN-16){half_s[15]}}, half_s};
            3'b100:  load_s = {{(XLEN-8){1'b0}}, byte_s};
            3'b101:  load_s = {{(XLEN-16){1'b0}}, half_s};
            default: load_s = bus.memData;
        endcase
    end

    // Writeback source select; memToReg[2]=1 encodings are reserved.
    always_comb begin
        reserved_s = bus.memToReg[2];
        case (bus.memToReg)
            3'b000:  wb_s = bus.ALUResult;
            3'b001:  wb_s = load_s;
            3'b010:  wb_s = bus.PCPlus4;
            3'b011:  wb_s = bus.imm;
            default: wb_s = {XLEN{1'b0}};
        endcase
    end

    assign we_s = bus.valid & bus.regWrite & (bus.RD != 5'd0) & ~reserved_s & ~rst;

    // Read ports: x0 reads zero, a same-cycle write to the address wins.
    always_comb begin
        if (bus.rs1 == 5'd0) begin
            rd1_s = {XLEN{1'b0}};
        end else if (we_s && (bus.rs1 == bus.RD)) begin
            rd1_s = wb_s;
        end else begin
            rd1_s = regs_r[bus.rs1];
        end
        if (bus.rs2 == 5'd0) begin
            rd2_s = {XLEN{1'b0}};
        end else if (we_s && (bus.rs2 == bus.RD)) begin
            rd2_s = wb_s;
        end else begin
            rd2_s = regs_r[bus.rs2];
        end
    end

    // Register file write; reset clears every entry and drops the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (we_s) begin
            regs_r[bus.RD] <= wb_s;
        end
    end

    // Retire counter: every valid slot retires, wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret_r <= 32'd0;
        end else if (bus.valid) begin
            instret_r <= instret_r + 32'd1;
        end
    end

    assign bus.wbData       = wb_s;
    assign bus.readData1    = rd1_s;
    assign bus.readData2    = rd2_s;
    assign bus.instretCount = instret_r;

endmodule
